dispatchdiv: RTL and testbench
==============================

# dispatchdiv

Dispatch-side sender for the divide issue queue. Buffers renamed divide instructions from the rename/dispatch stage in a small in-order FIFO, captures missing source operands from the common data bus (CDB) while they wait, and drives the `dispatch_*` interface of the divide issue queue, which accepts an entry on `dispatch_en && dispatch_ready`.

## Interface
- `DEPTH`, default 2: FIFO entries; power of two, at least 2.
- `TAG_W`, default 6: physical tag width.
- `DATA_W`, default 32: operand width.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `flush` in 1: synchronous clear of all entries (branch mispredict).
- `in_valid` in 1: upstream has a divide instruction.
- `in_ready` out 1: buffer can accept an instruction.
- `in_rdtag`, `in_rstag`, `in_rttag` in TAG_W: destination and source tags.
- `in_rsdata`, `in_rtdata` in DATA_W: source operand values, meaningful only when the matching valid bit is set.
- `in_rsvalid`, `in_rtvalid` in 1: source operand already available.
- `cdb_valid` in 1: CDB broadcast this cycle.
- `cdb_tag` in TAG_W: tag of the broadcast result.
- `cdb_data` in DATA_W: broadcast result value.
- `dispatch_rdtag`, `dispatch_rstag`, `dispatch_rttag` out TAG_W: head entry tags.
- `dispatch_rsdata`, `dispatch_rtdata` out DATA_W: head entry operands.
- `dispatch_rsvalid`, `dispatch_rtvalid` out 1: head entry operand valid bits.
- `dispatch_en` out 1: head entry offered to the issue queue.
- `dispatch_ready` in 1: issue queue accepts this cycle.

## Operation
- **Storage.** Circular FIFO of DEPTH entries. Each entry holds rdtag, rstag, rttag, rsdata, rtdata, rsvalid and rtvalid.
- **Pointers.** Head and tail pointers are log2(DEPTH)+1 bits; the extra MSB is a wrap bit. Empty when the pointers are equal. Full when the low bits are equal and the wrap bits differ.
- **`in_ready`.** Equals `!full`, from registered state only; there is no combinational path from `dispatch_ready`.
- **Enqueue.** Occurs when `in_valid && in_ready && !flush`; the entry is written at tail and tail increments.
- **Dequeue.** Occurs when `dispatch_en && dispatch_ready && !flush`; head increments.
- **Simultaneous enqueue and dequeue.** Both occur; count is unchanged. When full, no enqueue happens even if a dequeue occurs (no pass-through).
- **`dispatch_en`.** Equals `!empty`.
- **Dispatch outputs.** Reflect the head entry. When empty, all `dispatch_*` data, tag and valid outputs are driven 0.
- **CDB capture.** Every cycle with `cdb_valid`, each occupied entry with `rsvalid==0 && rstag==cdb_tag` sets rsvalid and loads rsdata from `cdb_data`. The rt operand is handled the same way, independently, so one broadcast may fill both operands.
- **Enqueue bypass.** An incoming operand with its valid bit clear whose tag matches a same-cycle CDB broadcast is written as valid with `cdb_data`.
- **Output bypass.** `dispatch_rsvalid`/`dispatch_rsdata` (and the rt pair) show a same-cycle CDB match combinationally, so a broadcast coinciding with dispatch is never lost.
- **Flush.** Empties the FIFO next cycle (pointers to 0) and has priority over a same-cycle enqueue and dequeue. Entry contents need not be cleared.

## Timing
- **Reset values.** `in_ready`=1, `dispatch_en`=0, all `dispatch_*` outputs 0, pointers 0, entry valid bits 0.
- **Enqueue latency.** An instruction enqueued in cycle N into an empty FIFO appears with `dispatch_en`=1 in cycle N+1.
- **Capture latency.** A CDB capture into a stored entry is visible in registered state at the next edge; at the head it is also visible in the same cycle via the output bypass.
- **Reset mid-operation.** Reset asynchronously empties the FIFO; any in-flight handshake is dropped.
- **Throughput.** Sustained 1 instruction per cycle when `dispatch_ready` is held high.

## Structure
- **Shared package/header.** TAG_W, DATA_W, and the entry field layout, shared with the divide issue queue and the other issue-queue dispatchers.
- **Sub-module.** `dispatchdiv_slot`: one entry's storage with CDB compare-and-capture logic, instantiated DEPTH times. Pointer and count logic lives in the top module.

## Test plan
- **Basic enqueue.** Reset, then enqueue rd=5, rs=3 (valid, 0x64), rt=4 (valid, 0x7) with `dispatch_ready`=1 → next cycle `dispatch_en`=1 with those values; the following cycle `dispatch_en`=0.
- **Fill and drain.** `dispatch_ready`=0, enqueue 2 instructions → `in_ready`=0 and a third request is ignored. Raise `dispatch_ready` → two dispatches in order, then `in_ready`=1.
- **Stored-entry capture.** Enqueue rs=9 invalid, then `cdb_valid` with tag=9, data=0xDEAD → head shows rsvalid=1, rsdata=0xDEAD. A broadcast on tag=10 leaves the entry unchanged.
- **Same-cycle bypasses.** A CDB tag matching the incoming rt during enqueue → stored valid with `cdb_data`. A CDB match during the head's dispatch → dispatched with valid=1 and the broadcast data.
- **Flush.** With 2 entries held, assert `flush` together with `in_valid` → next cycle empty, `dispatch_en`=0, `in_ready`=1, and the incoming instruction is not stored.
- **Full with dequeue.** When full, dequeue plus `in_valid` in the same cycle → one entry leaves, none enters; `in_ready`=1 next cycle.

Source files
------------

// File: rtl/dispatchdiv_pkg.sv
// Shared widths and entry layout for the divide issue queue and its dispatchers.
package dispatchdiv_pkg;

  localparam int DIV_TAG_W  = 6;
  localparam int DIV_DATA_W = 32;
  localparam int DIV_DEPTH  = 2;

  // Field order matches the dispatch_* bus and the issue-queue entry.
  typedef struct packed {
    logic [DIV_TAG_W-1:0]  rdtag;
    logic [DIV_TAG_W-1:0]  rstag;
    logic [DIV_TAG_W-1:0]  rttag;
    logic [DIV_DATA_W-1:0] rsdata;
    logic [DIV_DATA_W-1:0] rtdata;
    logic                  rsvalid;
    logic                  rtvalid;
  } div_entry_t;

endpackage

// File: rtl/dispatchdiv_slot.sv
// One buffered divide instruction: storage plus CDB compare-and-capture for both sources.
module dispatchdiv_slot #(
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              wr_en_i,
  input  logic [TAG_W-1:0]  wr_rdtag_i,
  input  logic [TAG_W-1:0]  wr_rstag_i,
  input  logic [TAG_W-1:0]  wr_rttag_i,
  input  logic [DATA_W-1:0] wr_rsdata_i,
  input  logic [DATA_W-1:0] wr_rtdata_i,
  input  logic              wr_rsvalid_i,
  input  logic              wr_rtvalid_i,
  input  logic              occupied_i,
  input  logic              cdb_valid_i,
  input  logic [TAG_W-1:0]  cdb_tag_i,
  input  logic [DATA_W-1:0] cdb_data_i,
  output logic [TAG_W-1:0]  rdtag_o,
  output logic [TAG_W-1:0]  rstag_o,
  output logic [TAG_W-1:0]  rttag_o,
  output logic [DATA_W-1:0] rsdata_o,
  output logic [DATA_W-1:0] rtdata_o,
  output logic              rsvalid_o,
  output logic              rtvalid_o
);

  logic [TAG_W-1:0]  rdtag_q, rdtag_d, rstag_q, rstag_d, rttag_q, rttag_d;
  logic [DATA_W-1:0] rsdata_q, rsdata_d, rtdata_q, rtdata_d;
  logic              rsvalid_q, rsvalid_d, rtvalid_q, rtvalid_d;
  logic              rs_hit, rt_hit, wr_rs_hit, wr_rt_hit;

  assign rs_hit    = cdb_valid_i && !rsvalid_q && (rstag_q == cdb_tag_i);
  assign rt_hit    = cdb_valid_i && !rtvalid_q && (rttag_q == cdb_tag_i);
  assign wr_rs_hit = cdb_valid_i && !wr_rsvalid_i && (wr_rstag_i == cdb_tag_i);
  assign wr_rt_hit = cdb_valid_i && !wr_rtvalid_i && (wr_rttag_i == cdb_tag_i);

  always_comb begin
    rdtag_d   = rdtag_q;
    rstag_d   = rstag_q;
    rttag_d   = rttag_q;
    rsdata_d  = rsdata_q;
    rtdata_d  = rtdata_q;
    rsvalid_d = rsvalid_q;
    rtvalid_d = rtvalid_q;
    if (wr_en_i) begin
      rdtag_d   = wr_rdtag_i;
      rstag_d   = wr_rstag_i;
      rttag_d   = wr_rttag_i;
      rsvalid_d = wr_rsvalid_i || wr_rs_hit;
      rtvalid_d = wr_rtvalid_i || wr_rt_hit;
      rsdata_d  = wr_rs_hit ? cdb_data_i : wr_rsdata_i;
      rtdata_d  = wr_rt_hit ? cdb_data_i : wr_rtdata_i;
    end else if (occupied_i) begin
      if (rs_hit) begin
        rsvalid_d = 1'b1;
        rsdata_d  = cdb_data_i;
      end
      if (rt_hit) begin
        rtvalid_d = 1'b1;
        rtdata_d  = cdb_data_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rdtag_q   <= '0;
      rstag_q   <= '0;
      rttag_q   <= '0;
      rsdata_q  <= '0;
      rtdata_q  <= '0;
      rsvalid_q <= 1'b0;
      rtvalid_q <= 1'b0;
    end else begin
      rdtag_q   <= rdtag_d;
      rstag_q   <= rstag_d;
      rttag_q   <= rttag_d;
      rsdata_q  <= rsdata_d;
      rtdata_q  <= rtdata_d;
      rsvalid_q <= rsvalid_d;
      rtvalid_q <= rtvalid_d;
    end
  end

  // Same-cycle view so a broadcast coinciding with dispatch reaches the issue queue.
  assign rdtag_o   = rdtag_q;
  assign rstag_o   = rstag_q;
  assign rttag_o   = rttag_q;
  assign rsvalid_o = rsvalid_q || rs_hit;
  assign rtvalid_o = rtvalid_q || rt_hit;
  assign rsdata_o  = rs_hit ? cdb_data_i : rsdata_q;
  assign rtdata_o  = rt_hit ? cdb_data_i : rtdata_q;

endmodule

// File: rtl/dispatchdiv.sv
// In-order buffer between rename/dispatch and the divide issue queue, with CDB operand capture.
module dispatchdiv
  import dispatchdiv_pkg::*;
#(
  parameter int DEPTH  = DIV_DEPTH,
  parameter int TAG_W  = DIV_TAG_W,
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [TAG_W-1:0]  in_rdtag,
  input  logic [TAG_W-1:0]  in_rstag,
  input  logic [TAG_W-1:0]  in_rttag,
  input  logic [DATA_W-1:0] in_rsdata,
  input  logic [DATA_W-1:0] in_rtdata,
  input  logic              in_rsvalid,
  input  logic              in_rtvalid,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic [TAG_W-1:0]  dispatch_rdtag,
  output logic [TAG_W-1:0]  dispatch_rstag,
  output logic [TAG_W-1:0]  dispatch_rttag,
  output logic [DATA_W-1:0] dispatch_rsdata,
  output logic [DATA_W-1:0] dispatch_rtdata,
  output logic              dispatch_rsvalid,
  output logic              dispatch_rtvalid,
  output logic              dispatch_en,
  input  logic              dispatch_ready
);

  localparam int AW = $clog2(DEPTH);

  // Handshakes: a transfer happens on a cycle where valid && ready are both high
  // at the rising edge (in_valid/in_ready upstream, dispatch_en/dispatch_ready
  // downstream); valid never depends on ready, and in_ready comes from registers only.
  logic [AW:0]   head_q, head_d, tail_q, tail_d, count;
  logic [AW-1:0] head_idx, tail_idx;
  logic          empty, full, enq, deq;

  logic [TAG_W-1:0]  s_rdtag  [DEPTH];
  logic [TAG_W-1:0]  s_rstag  [DEPTH];
  logic [TAG_W-1:0]  s_rttag  [DEPTH];
  logic [DATA_W-1:0] s_rsdata [DEPTH];
  logic [DATA_W-1:0] s_rtdata [DEPTH];
  logic              s_rsvalid[DEPTH];
  logic              s_rtvalid[DEPTH];

  assign head_idx = head_q[AW-1:0];
  assign tail_idx = tail_q[AW-1:0];
  assign count    = tail_q - head_q;
  assign empty    = (head_q == tail_q);
  assign full     = (head_idx == tail_idx) && (head_q[AW] != tail_q[AW]);
  assign in_ready = !full;
  assign enq      = in_valid && !full && !flush;
  assign deq      = !empty && dispatch_ready && !flush;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      if (enq) tail_d = tail_q + 1'b1;
      if (deq) head_d = head_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [AW-1:0] off;
    logic          occ;
    // Slot i is live when its distance from head is below the current count.
    assign off = AW'(i) - head_idx;
    assign occ = ({1'b0, off} < count);

    dispatchdiv_slot #(
      .TAG_W (TAG_W),
      .DATA_W(DATA_W)
    ) u_slot (
      .clk_i       (clk),
      .reset_i     (reset),
      .wr_en_i     (enq && (tail_idx == AW'(i))),
      .wr_rdtag_i  (in_rdtag),
      .wr_rstag_i  (in_rstag),
      .wr_rttag_i  (in_rttag),
      .wr_rsdata_i (in_rsdata),
      .wr_rtdata_i (in_rtdata),
      .wr_rsvalid_i(in_rsvalid),
      .wr_rtvalid_i(in_rtvalid),
      .occupied_i  (occ),
      .cdb_valid_i (cdb_valid),
      .cdb_tag_i   (cdb_tag),
      .cdb_data_i  (cdb_data),
      .rdtag_o     (s_rdtag[i]),
      .rstag_o     (s_rstag[i]),
      .rttag_o     (s_rttag[i]),
      .rsdata_o    (s_rsdata[i]),
      .rtdata_o    (s_rtdata[i]),
      .rsvalid_o   (s_rsvalid[i]),
      .rtvalid_o   (s_rtvalid[i])
    );
  end

  assign dispatch_en      = !empty;
  assign dispatch_rdtag   = empty ? '0 : s_rdtag[head_idx];
  assign dispatch_rstag   = empty ? '0 : s_rstag[head_idx];
  assign dispatch_rttag   = empty ? '0 : s_rttag[head_idx];
  assign dispatch_rsdata  = empty ? '0 : s_rsdata[head_idx];
  assign dispatch_rtdata  = empty ? '0 : s_rtdata[head_idx];
  assign dispatch_rsvalid = empty ? 1'b0 : s_rsvalid[head_idx];
  assign dispatch_rtvalid = empty ? 1'b0 : s_rtvalid[head_idx];

endmodule

// File: tb/tb_dispatchdiv.sv
// Bench for dispatchdiv: directed test-plan sequences plus random traffic against a queue model.
module tb_dispatchdiv;

  localparam int DEPTH  = 2;
  localparam int TAG_W  = 6;
  localparam int DATA_W = 32;
  localparam int EW     = 3 * TAG_W + 2 * DATA_W + 2;

  typedef struct packed {
    logic [TAG_W-1:0]  rd;
    logic [TAG_W-1:0]  rs;
    logic [TAG_W-1:0]  rt;
    logic [DATA_W-1:0] rsd;
    logic [DATA_W-1:0] rtd;
    logic              rsv;
    logic              rtv;
  } ent_t;

  logic              clk, reset, flush;
  logic              in_valid, in_ready;
  logic [TAG_W-1:0]  in_rdtag, in_rstag, in_rttag;
  logic [DATA_W-1:0] in_rsdata, in_rtdata;
  logic              in_rsvalid, in_rtvalid;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic [TAG_W-1:0]  dispatch_rdtag, dispatch_rstag, dispatch_rttag;
  logic [DATA_W-1:0] dispatch_rsdata, dispatch_rtdata;
  logic              dispatch_rsvalid, dispatch_rtvalid, dispatch_en, dispatch_ready;

  logic [EW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  dispatchdiv #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rdtag(in_rdtag), .in_rstag(in_rstag), .in_rttag(in_rttag),
    .in_rsdata(in_rsdata), .in_rtdata(in_rtdata),
    .in_rsvalid(in_rsvalid), .in_rtvalid(in_rtvalid),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .dispatch_rdtag(dispatch_rdtag), .dispatch_rstag(dispatch_rstag),
    .dispatch_rttag(dispatch_rttag), .dispatch_rsdata(dispatch_rsdata),
    .dispatch_rtdata(dispatch_rtdata), .dispatch_rsvalid(dispatch_rsvalid),
    .dispatch_rtvalid(dispatch_rtvalid), .dispatch_en(dispatch_en),
    .dispatch_ready(dispatch_ready)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic ent_t dut_head();
    ent_t e;
    e = {dispatch_rdtag, dispatch_rstag, dispatch_rttag, dispatch_rsdata,
         dispatch_rtdata, dispatch_rsvalid, dispatch_rtvalid};
    return e;
  endfunction

  // Operand data carries no meaning while its valid bit is clear.
  function automatic ent_t mask(input ent_t e);
    ent_t m;
    m = e;
    if (!m.rsv) m.rsd = '0;
    if (!m.rtv) m.rtd = '0;
    return m;
  endfunction

  // Driver tasks
  task automatic idle();
    in_valid  = 1'b0;
    cdb_valid = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic set_in(input int rd, input int rs, input int rt, input logic [31:0] rsd,
                        input logic [31:0] rtd, input logic rsv, input logic rtv);
    in_valid   = 1'b1;
    in_rdtag   = TAG_W'(rd);
    in_rstag   = TAG_W'(rs);
    in_rttag   = TAG_W'(rt);
    in_rsdata  = rsd;
    in_rtdata  = rtd;
    in_rsvalid = rsv;
    in_rtvalid = rtv;
  endtask

  task automatic set_cdb(input int tag, input logic [31:0] data);
    cdb_valid = 1'b1;
    cdb_tag   = TAG_W'(tag);
    cdb_data  = data;
  endtask

  // Compare this cycle's outputs against the model, then advance model and clock.
  task automatic cycle();
    ent_t e;
    logic enq, deq;
    #1;
    if (cdb_valid) begin
      for (int i = 0; i < exp_q.size(); i++) begin
        e = exp_q[i];
        if (!e.rsv && e.rs == cdb_tag) begin e.rsv = 1'b1; e.rsd = cdb_data; end
        if (!e.rtv && e.rt == cdb_tag) begin e.rtv = 1'b1; e.rtd = cdb_data; end
        exp_q[i] = e;
      end
    end
    if (exp_q.size() == 0) begin
      check_eq("dispatch_en_idle", dispatch_en, 1'b0);
      check_eq("idle_outputs", dut_head(), '0);
    end else begin
      check_eq("dispatch_en_busy", dispatch_en, 1'b1);
      check_eq("head_entry", mask(dut_head()), mask(exp_q[0]));
    end
    check_eq("in_ready", in_ready, exp_q.size() < DEPTH);
    enq = in_valid && (exp_q.size() < DEPTH);
    deq = (exp_q.size() > 0) && dispatch_ready;
    if (flush) exp_q.delete();
    else begin
      if (deq) void'(exp_q.pop_front());
      if (enq) begin
        e = {in_rdtag, in_rstag, in_rttag, in_rsdata, in_rtdata, in_rsvalid, in_rtvalid};
        if (!e.rsv && cdb_valid && e.rs == cdb_tag) begin e.rsv = 1'b1; e.rsd = cdb_data; end
        if (!e.rtv && cdb_valid && e.rt == cdb_tag) begin e.rtv = 1'b1; e.rtd = cdb_data; end
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    dispatch_ready = 1'b0;
    idle();
    set_in(0, 0, 0, 0, 0, 1'b0, 1'b0);
    in_valid = 1'b0;
    cdb_tag = '0;
    cdb_data = '0;
    @(negedge clk);
    check_eq("reset_in_ready", in_ready, 1'b1);
    check_eq("reset_dispatch_en", dispatch_en, 1'b0);
    check_eq("reset_outputs", dut_head(), '0);
    reset = 1'b0;

    // Basic enqueue
    dispatch_ready = 1'b1;
    set_in(5, 3, 4, 32'h64, 32'h7, 1'b1, 1'b1);
    cycle();
    idle();
    #1 check_eq("basic_rsdata", dispatch_rsdata, 32'h64);
    check_eq("basic_rdtag", dispatch_rdtag, 6'd5);
    cycle();
    cycle();

    // Fill and drain
    dispatch_ready = 1'b0;
    set_in(1, 2, 3, 32'h11, 32'h22, 1'b1, 1'b1); cycle();
    set_in(6, 7, 8, 32'h33, 32'h44, 1'b1, 1'b1); cycle();
    set_in(9, 9, 9, 32'h55, 32'h66, 1'b1, 1'b1);
    #1 check_eq("full_in_ready", in_ready, 1'b0);
    cycle();
    idle();
    dispatch_ready = 1'b1;
    cycle();
    cycle();
    check_eq("drained_in_ready", in_ready, 1'b1);
    cycle();

    // Stored-entry capture, including a non-matching broadcast
    dispatch_ready = 1'b0;
    set_in(11, 9, 15, 32'h0, 32'h5, 1'b0, 1'b1); cycle();
    idle(); set_cdb(10, 32'h1234); cycle();
    idle(); set_cdb(9, 32'hDEAD); cycle();
    idle();
    #1 check_eq("capture_rsvalid", dispatch_rsvalid, 1'b1);
    check_eq("capture_rsdata", dispatch_rsdata, 32'hDEAD);
    dispatch_ready = 1'b1;
    cycle();

    // Same-cycle bypasses: enqueue, dispatch, and both operands from one broadcast
    dispatch_ready = 1'b0;
    set_in(13, 14, 12, 32'h1, 32'h0, 1'b1, 1'b0); set_cdb(12, 32'hBEEF); cycle();
    idle();
    #1 check_eq("enq_bypass_rtdata", dispatch_rtdata, 32'hBEEF);
    set_in(21, 20, 22, 32'h0, 32'h3, 1'b0, 1'b1); cycle();
    idle(); dispatch_ready = 1'b1; cycle();
    set_cdb(20, 32'hCAFE);
    #1 check_eq("deq_bypass_rsvalid", dispatch_rsvalid, 1'b1);
    check_eq("deq_bypass_rsdata", dispatch_rsdata, 32'hCAFE);
    cycle();
    idle(); dispatch_ready = 1'b0;
    set_in(31, 30, 30, 32'h0, 32'h0, 1'b0, 1'b0); cycle();
    idle(); set_cdb(30, 32'h5A5A); cycle();
    idle(); dispatch_ready = 1'b1; cycle();

    // Flush with a concurrent enqueue request
    dispatch_ready = 1'b0;
    set_in(1, 1, 1, 32'h1, 32'h1, 1'b1, 1'b1); cycle();
    set_in(2, 2, 2, 32'h2, 32'h2, 1'b1, 1'b1); cycle();
    set_in(3, 3, 3, 32'h3, 32'h3, 1'b1, 1'b1); flush = 1'b1; cycle();
    idle();
    #1 check_eq("flush_dispatch_en", dispatch_en, 1'b0);
    check_eq("flush_in_ready", in_ready, 1'b1);
    cycle();

    // Full with simultaneous dequeue: no pass-through
    set_in(4, 4, 4, 32'h4, 32'h4, 1'b1, 1'b1); cycle();
    set_in(5, 5, 5, 32'h5, 32'h5, 1'b1, 1'b1); cycle();
    set_in(6, 6, 6, 32'h6, 32'h6, 1'b1, 1'b1); dispatch_ready = 1'b1; cycle();
    idle(); dispatch_ready = 1'b0;
    #1 check_eq("full_deq_in_ready", in_ready, 1'b1);
    check_eq("full_deq_head", dispatch_rdtag, 6'd5);
    cycle();

    // Asynchronous reset mid-operation
    set_in(7, 7, 7, 32'h7, 32'h7, 1'b1, 1'b1); cycle();
    idle();
    #2 reset = 1'b1;
    #1 check_eq("async_reset_en", dispatch_en, 1'b0);
    check_eq("async_reset_ready", in_ready, 1'b1);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;

    // Random traffic with a small tag space so CDB hits are frequent
    for (int n = 0; n < 400; n++) begin
      idle();
      if ($urandom_range(0, 1) == 1)
        set_in($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
               $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) set_cdb($urandom_range(0, 7), $urandom);
      dispatch_ready = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 24) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
